persist_state_bank: RTL and testbench
=====================================

// Module: persist_state_bank
// PURPOSE
//  Parametrised always-on persistence store for the tag: inventoried flags for all
//  sessions, SL flag, EPC-write counter, and per-sensor sample counters for
//  NUM_SENS channels. Includes S1 flag decay and a multi-cycle factory-clear
//  sequencer. Sits beside mem; applies the decoded command on each packet_complete.
// PARAMETERS
//  NUM_SENS   3     number of sensor channels (>=1)
//  CNT_W      6     width of EPC and sensor counters
//  CODE_W     16    width of stored calibration code word
//  PERSIST_S1 1000  clk cycles a session-1 flag holds B before reverting to A (>=1)
// PORTS
//  clk            in   1                 system clock, rising edge
//  reset          in   1                 asynchronous, active-low reset
//  factory_reset  in   1                 sync pulse: start clear sequence
//  packet_complete in  1                 command strobe; cmd_* sampled this cycle
//  cmd_op         in   3                 0 NOP,1 INV_TOGGLE,2 INV_SET,3 SL_SET,4 SL_CLR,5 SL_TOGGLE,6 EPC_WRITE,7 WRAP_CLR
//  cmd_session    in   2                 session index for INV_* ops
//  cmd_value      in   1                 flag value for INV_SET (0=A,1=B)
//  ADC_data_ready in   1                 sample strobe for sample_chan
//  sample_chan    in   $clog2(NUM_SENS)  channel to count (max(1,..) bits)
//  code_load      in   1                 load code_in into code_out
//  code_in        in   CODE_W            calibration code
//  inven_flags    out  4                 per-session inventoried flag (1=B)
//  sl_flag        out  1                 SL flag
//  epc_count      out  CNT_W             EPC write counter
//  sens_count     out  NUM_SENS*CNT_W    channel i at [i*CNT_W +: CNT_W]
//  sens_wrap      out  NUM_SENS          sticky per-channel wrap/saturation flag
//  code_out       out  CODE_W            stored code
//  busy           out  1                 high during clear sequence
//  cmd_drop       out  1                 1-cycle pulse: strobe ignored while busy
// BEHAVIOUR
//  - reset low: all outputs 0, FSM IDLE, S1 timer 0; takes effect immediately.
//  - FSM IDLE/CLEAR. IDLE+factory_reset -> CLEAR, idx=0. CLEAR clears one counter per
//    cycle: idx 0..NUM_SENS-1 -> sens_count[idx], sens_wrap[idx]; idx NUM_SENS ->
//    epc_count, inven_flags, sl_flag, code_out, S1 timer; then IDLE. busy=1 for exactly
//    NUM_SENS+1 cycles starting the cycle after factory_reset. factory_reset while busy ignored.
//  - All updates registered: effect visible 1 cycle after strobe.
//  - In CLEAR, packet_complete, ADC_data_ready and code_load are ignored;
//    packet_complete (op!=NOP) pulses cmd_drop next cycle.
//  - INV_TOGGLE inverts inven_flags[cmd_session]; INV_SET writes cmd_value.
//  - S1 decay: any op writing inven_flags[1]=1 loads timer=PERSIST_S1; timer
//    decrements each cycle while nonzero; on 1->0 transition flag[1] cleared. Write of 0
//    clears timer. Sessions 0,2,3 never decay.
//  - SL_SET/CLR/TOGGLE act on sl_flag. EPC_WRITE: epc_count+1. WRAP_CLR clears sens_wrap.
//  - ADC_data_ready: sens_count[sample_chan]+1 modulo 2^CNT_W; on max->0 set
//    sens_wrap[chan]. sample_chan>=NUM_SENS ignored.
//  - Simultaneous strobes (command, sample, code_load) all apply in the same cycle;
//    WRAP_CLR and a wrap on the same cycle leaves sens_wrap set.
//  - Widths: counters unsigned CNT_W; no carry out beyond sens_wrap.
// CONFIGURATION
//  PERSIST_SAT_EN defined: sensor and EPC counters saturate at 2^CNT_W-1;
//    sens_wrap[i] sets on attempted increment at max. Undefined: modulo wrap as above.
// TESTING
//  1 reset low mid-run, count nonzero -> all outputs 0 immediately; busy=0.
//  2 INV_TOGGLE session1 -> inven_flags=4'b0010 next cycle; after PERSIST_S1 cycles -> 0;
//    retoggle at cycle 500 -> flag held 1000 cycles from retoggle.
//  3 CNT_W=6, 64 samples chan2 -> sens_count[2]=0, sens_wrap[2]=1; with SAT_EN count=63,
//    wrap=1 on 64th sample.
//  4 factory_reset, NUM_SENS=3 -> busy high 4 cycles; EPC_WRITE during busy -> cmd_drop
//    pulse, epc_count stays 0.
//  5 EPC_WRITE + ADC_data_ready chan0 + code_load 16'hBEEF same cycle -> epc_count=1,
//    sens_count[0]=1, code_out=16'hBEEF.
//  6 reset low at CLEAR idx=1 -> all 0, IDLE; first cycle after release busy=0.

Source files
------------

// File: rtl/persist_state_bank.sv
// persist_state_bank - always-on tag persistence: inventoried/SL flags, EPC and sensor counters, S1 decay, factory clear.
// Optional build macro PERSIST_SAT_EN: sensor and EPC counters saturate instead of wrapping.
module persist_state_bank #(
  parameter int NUM_SENS   = 3,
  parameter int CNT_W      = 6,
  parameter int CODE_W     = 16,
  parameter int PERSIST_S1 = 1000,
  localparam int CH_W      = (NUM_SENS > 1) ? $clog2(NUM_SENS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      factory_reset,
  input  logic                      packet_complete,
  input  logic [2:0]                cmd_op,
  input  logic [1:0]                cmd_session,
  input  logic                      cmd_value,
  input  logic                      ADC_data_ready,
  input  logic [CH_W-1:0]           sample_chan,
  input  logic                      code_load,
  input  logic [CODE_W-1:0]         code_in,
  output logic [3:0]                inven_flags,
  output logic                      sl_flag,
  output logic [CNT_W-1:0]          epc_count,
  output logic [NUM_SENS*CNT_W-1:0] sens_count,
  output logic [NUM_SENS-1:0]       sens_wrap,
  output logic [CODE_W-1:0]         code_out,
  output logic                      busy,
  output logic                      cmd_drop
);

  localparam int IDX_W = $clog2(NUM_SENS + 1);
  localparam int TMR_W = $clog2(PERSIST_S1 + 1);

  localparam logic [2:0] OP_NOP        = 3'd0;
  localparam logic [2:0] OP_INV_TOGGLE = 3'd1;
  localparam logic [2:0] OP_INV_SET    = 3'd2;
  localparam logic [2:0] OP_SL_SET     = 3'd3;
  localparam logic [2:0] OP_SL_CLR     = 3'd4;
  localparam logic [2:0] OP_SL_TOGGLE  = 3'd5;
  localparam logic [2:0] OP_EPC_WRITE  = 3'd6;
  localparam logic [2:0] OP_WRAP_CLR   = 3'd7;

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_idx;
  logic                r_busy;
  logic                r_cmd_drop;
  logic [3:0]          r_flags;
  logic [TMR_W-1:0]    r_timer;
  logic                r_sl;
  logic [CNT_W-1:0]    r_epc;
  logic [CNT_W-1:0]    r_cnt [NUM_SENS];
  logic [NUM_SENS-1:0] r_wrap;
  logic [CODE_W-1:0]   r_code;

  logic                w_cmd;
  logic                w_smp;
  logic [3:0]          w_flags;
  logic [TMR_W-1:0]    w_timer;
  logic                w_sl;
  logic [CNT_W-1:0]    w_epc;
  logic [CNT_W-1:0]    w_cnt [NUM_SENS];
  logic [NUM_SENS-1:0] w_wrap;
  logic [CODE_W-1:0]   w_code;

  assign w_cmd = packet_complete && !r_busy;
  assign w_smp = ADC_data_ready && !r_busy;

  always_comb begin
    w_flags = r_flags;
    w_timer = r_timer;
    w_sl    = r_sl;
    w_epc   = r_epc;
    w_wrap  = r_wrap;
    w_code  = r_code;
    for (int i = 0; i < NUM_SENS; i++) w_cnt[i] = r_cnt[i];

    // Session-1 decay keeps running even during a clear; the final clear step zeroes it.
    if (r_timer != '0) begin
      w_timer = r_timer - 1'b1;
      if (r_timer == TMR_W'(1)) w_flags[1] = 1'b0;
    end

    if (w_cmd) begin
      case (cmd_op)
        OP_INV_TOGGLE: w_flags[cmd_session] = ~r_flags[cmd_session];
        OP_INV_SET:    w_flags[cmd_session] = cmd_value;
        OP_SL_SET:     w_sl = 1'b1;
        OP_SL_CLR:     w_sl = 1'b0;
        OP_SL_TOGGLE:  w_sl = ~r_sl;
        OP_EPC_WRITE: begin
`ifdef PERSIST_SAT_EN
          if (r_epc != '1) w_epc = r_epc + 1'b1;
`else
          w_epc = r_epc + 1'b1;
`endif
        end
        OP_WRAP_CLR:   w_wrap = '0;
        default:       ;
      endcase
      if ((cmd_op == OP_INV_TOGGLE || cmd_op == OP_INV_SET) && cmd_session == 2'd1)
        w_timer = w_flags[1] ? TMR_W'(PERSIST_S1) : '0;
    end

    // Sample increment is applied after WRAP_CLR so a same-cycle wrap stays set.
    if (w_smp) begin
      for (int i = 0; i < NUM_SENS; i++) begin
        if (sample_chan == CH_W'(i)) begin
          if (r_cnt[i] == '1) begin
            w_wrap[i] = 1'b1;
`ifndef PERSIST_SAT_EN
            w_cnt[i] = '0;
`endif
          end else begin
            w_cnt[i] = r_cnt[i] + 1'b1;
          end
        end
      end
    end

    if (code_load && !r_busy) w_code = code_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_busy     <= 1'b0;
      r_cmd_drop <= 1'b0;
      r_flags    <= '0;
      r_timer    <= '0;
      r_sl       <= 1'b0;
      r_epc      <= '0;
      r_wrap     <= '0;
      r_code     <= '0;
      for (int i = 0; i < NUM_SENS; i++) r_cnt[i] <= '0;
    end else begin
      r_flags    <= w_flags;
      r_timer    <= w_timer;
      r_sl       <= w_sl;
      r_epc      <= w_epc;
      r_wrap     <= w_wrap;
      r_code     <= w_code;
      for (int i = 0; i < NUM_SENS; i++) r_cnt[i] <= w_cnt[i];
      r_cmd_drop <= r_busy && packet_complete && (cmd_op != OP_NOP);

      case (r_state)
        S_IDLE: begin
          if (factory_reset) begin
            r_state <= S_CLEAR;
            r_busy  <= 1'b1;
            r_idx   <= '0;
          end
        end
        S_CLEAR: begin
          if (r_idx == IDX_W'(NUM_SENS)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_flags <= '0;
            r_timer <= '0;
            r_sl    <= 1'b0;
            r_epc   <= '0;
            r_code  <= '0;
          end else begin
            for (int i = 0; i < NUM_SENS; i++) begin
              if (r_idx == IDX_W'(i)) begin
                r_cnt[i]  <= '0;
                r_wrap[i] <= 1'b0;
              end
            end
            r_idx <= r_idx + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_SENS; g++) begin : g_cnt_out
    assign sens_count[g*CNT_W +: CNT_W] = r_cnt[g];
  end

  assign inven_flags = r_flags;
  assign sl_flag     = r_sl;
  assign epc_count   = r_epc;
  assign sens_wrap   = r_wrap;
  assign code_out    = r_code;
  assign busy        = r_busy;
  assign cmd_drop    = r_cmd_drop;

endmodule

// File: tb/tb_persist_state_bank.sv
// tb/tb_persist_state_bank.sv - randomized and directed bench for persist_state_bank against a behavioural model.
module tb_persist_state_bank;

  localparam int NS  = 3;
  localparam int CW  = 6;
  localparam int PS1 = 1000;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          fr, pc, val, adc, cl;
  logic [2:0]    op;
  logic [1:0]    sess, chan;
  logic [15:0]   cin;
  logic [3:0]    inven_flags;
  logic          sl_flag, busy, cmd_drop;
  logic [CW-1:0] epc_count;
  logic [NS*CW-1:0] sens_count;
  logic [NS-1:0] sens_wrap;
  logic [15:0]   code_out;

  persist_state_bank #(.NUM_SENS(NS), .CNT_W(CW), .CODE_W(16), .PERSIST_S1(PS1)) dut (
    .clk(clk), .reset(reset), .factory_reset(fr), .packet_complete(pc),
    .cmd_op(op), .cmd_session(sess), .cmd_value(val), .ADC_data_ready(adc),
    .sample_chan(chan), .code_load(cl), .code_in(cin), .inven_flags(inven_flags),
    .sl_flag(sl_flag), .epc_count(epc_count), .sens_count(sens_count),
    .sens_wrap(sens_wrap), .code_out(code_out), .busy(busy), .cmd_drop(cmd_drop)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: flag expiry is tracked as an absolute edge number.
  int m_flags [4];
  int m_sl, m_epc, m_code, m_drop;
  int m_cnt [NS];
  int m_wrap [NS];
  int m_step;
  int m_expire;
  int edge_n = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_flags[i] = 0;
    for (int i = 0; i < NS; i++) begin m_cnt[i] = 0; m_wrap[i] = 0; end
    m_sl = 0; m_epc = 0; m_code = 0; m_drop = 0; m_step = -1; m_expire = -1;
  endtask

  task automatic set_flag(input int s, input int v);
    m_flags[s] = v;
    if (s == 1) m_expire = v ? edge_n + PS1 : -1;
  endtask

  task automatic model_step();
    bit act;
    edge_n++;
    act = (m_step < 0);
    if (m_expire == edge_n) begin m_flags[1] = 0; m_expire = -1; end
    m_drop = (!act && pc && op != 3'd0) ? 1 : 0;
    if (act) begin
      if (pc) begin
        case (op)
          3'd1: set_flag(int'(sess), m_flags[sess] ? 0 : 1);
          3'd2: set_flag(int'(sess), int'(val));
          3'd3: m_sl = 1;
          3'd4: m_sl = 0;
          3'd5: m_sl = m_sl ? 0 : 1;
`ifdef PERSIST_SAT_EN
          3'd6: m_epc = (m_epc < MAXC) ? m_epc + 1 : MAXC;
`else
          3'd6: m_epc = (m_epc + 1) % (MAXC + 1);
`endif
          3'd7: for (int i = 0; i < NS; i++) m_wrap[i] = 0;
          default: ;
        endcase
      end
      if (adc && int'(chan) < NS) begin
        if (m_cnt[chan] == MAXC) begin
          m_wrap[chan] = 1;
`ifdef PERSIST_SAT_EN
          m_cnt[chan] = MAXC;
`else
          m_cnt[chan] = 0;
`endif
        end else m_cnt[chan] = m_cnt[chan] + 1;
      end
      if (cl) m_code = int'(cin);
      if (fr) m_step = 0;
    end else begin
      if (m_step < NS) begin
        m_cnt[m_step] = 0; m_wrap[m_step] = 0;
      end else begin
        for (int i = 0; i < 4; i++) m_flags[i] = 0;
        m_sl = 0; m_epc = 0; m_code = 0; m_expire = -1;
      end
      m_step++;
      if (m_step > NS) m_step = -1;
    end
  endtask

  task automatic check_all();
    logic [3:0] ef;
    logic [NS*CW-1:0] ec;
    logic [NS-1:0] ew;
    for (int i = 0; i < 4; i++) ef[i] = m_flags[i][0];
    for (int i = 0; i < NS; i++) begin
      ec[i*CW +: CW] = m_cnt[i][CW-1:0];
      ew[i] = m_wrap[i][0];
    end
    check_eq("inven_flags", 64'(inven_flags), 64'(ef));
    check_eq("sl_flag", 64'(sl_flag), 64'(m_sl));
    check_eq("epc_count", 64'(epc_count), 64'(m_epc));
    check_eq("sens_count", 64'(sens_count), 64'(ec));
    check_eq("sens_wrap", 64'(sens_wrap), 64'(ew));
    check_eq("code_out", 64'(code_out), 64'(m_code));
    check_eq("busy", 64'(busy), 64'(m_step >= 0));
    check_eq("cmd_drop", 64'(cmd_drop), 64'(m_drop));
  endtask

  task automatic idle_in();
    fr = 0; pc = 0; op = 0; sess = 0; val = 0; adc = 0; chan = 0; cl = 0; cin = 0;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 20 && busy; k++) cycle();
    check_eq("idle_wait", 64'(busy), 64'd0);
  endtask

  task automatic async_reset_check(input string tag);
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    idle_in();
    #2;
    reset = 1'b1;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int n;
    idle_in();
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b1;

    // S1 decay: toggle holds B for PERSIST_S1 cycles, then a re-set restarts the hold.
    pc = 1; op = 3'd1; sess = 2'd1;
    cycle();
    idle_in();
    check_eq("s1_set", 64'(inven_flags), 64'h2);
    cycles(PS1 - 1);
    check_eq("s1_hold_end", 64'(inven_flags), 64'h2);
    cycle();
    check_eq("s1_decayed", 64'(inven_flags), 64'h0);
    pc = 1; op = 3'd1; sess = 2'd1;
    cycle();
    idle_in();
    cycles(499);
    pc = 1; op = 3'd2; sess = 2'd1; val = 1'b1;
    cycle();
    idle_in();
    cycles(PS1 - 1);
    check_eq("s1_rehold_end", 64'(inven_flags), 64'h2);
    cycle();
    check_eq("s1_redecayed", 64'(inven_flags), 64'h0);

    // Simultaneous command, sample and code load.
    pc = 1; op = 3'd6; adc = 1; chan = 0; cl = 1; cin = 16'hBEEF;
    cycle();
    idle_in();
    check_eq("simul_epc", 64'(epc_count), 64'd1);
    check_eq("simul_cnt0", 64'(sens_count[0 +: CW]), 64'd1);
    check_eq("simul_code", 64'(code_out), 64'hBEEF);

    // Channel-2 rollover / saturation on the 64th sample.
    adc = 1; chan = 2'd2;
    cycles(MAXC);
    check_eq("cnt2_max", 64'(sens_count[2*CW +: CW]), 64'(MAXC));
    check_eq("wrap2_pre", 64'(sens_wrap[2]), 64'd0);
    cycle();
    idle_in();
`ifdef PERSIST_SAT_EN
    check_eq("cnt2_sat", 64'(sens_count[2*CW +: CW]), 64'(MAXC));
`else
    check_eq("cnt2_wrap", 64'(sens_count[2*CW +: CW]), 64'd0);
`endif
    check_eq("wrap2_set", 64'(sens_wrap[2]), 64'd1);

    // Factory clear: busy length and a dropped EPC_WRITE.
    async_reset_check("pre_clear_reset");
    fr = 1;
    cycle();
    fr = 0;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      if (!busy) break;
      n++;
      if (k == 0) begin pc = 1; op = 3'd6; end
      cycle();
      if (k == 0) begin
        idle_in();
        check_eq("drop_pulse", 64'(cmd_drop), 64'd1);
        check_eq("drop_epc", 64'(epc_count), 64'd0);
      end
    end
    check_eq("busy_len", 64'(n), 64'(NS + 1));

    // Randomized traffic.
    for (int k = 0; k < 1500; k++) begin
      pc = ($urandom % 2) == 0;
      op = 3'($urandom % 8);
      sess = 2'($urandom % 4);
      val = 1'($urandom % 2);
      adc = ($urandom % 3) != 0;
      chan = 2'($urandom % 4);
      cl = ($urandom % 8) == 0;
      cin = 16'($urandom);
      fr = ($urandom % 100) == 0;
      cycle();
    end
    idle_in();

    // Reset mid-run with state nonzero.
    pc = 1; op = 3'd6; adc = 1; chan = 0;
    wait_idle();
    cycle();
    idle_in();
    async_reset_check("midrun_reset");

    // Reset while the clear sequencer sits at idx 1.
    fr = 1;
    cycle();
    fr = 0;
    cycle();
    check_eq("clr_busy_idx1", 64'(busy), 64'd1);
    async_reset_check("clear_reset");
    cycle();
    check_eq("post_clear_reset_busy", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
